// File: rtl/blackjack_pkg.sv
// Shared blackjack datapath types: deck constants, shoe FSM states, the card
// record and the point-value rule also used by the score accumulators.
package blackjack_pkg;

    localparam int          DECK_SIZE = 52;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHUFFLE,
        ST_CHECK
    } shoe_state_t;

    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
        logic [3:0] point;
        logic       is_ace;
    } card_t;

    // Faces count 10, ace counts 1 (soft-ace handling lives in the accumulators).
    function automatic logic [3:0] point_of(input logic [3:0] rank);
        return (rank >= 4'd10) ? 4'd10 : rank;
    endfunction

    // Fold a 6-bit random value onto a deck index 0..51.
    function automatic logic [5:0] fold_index(input logic [5:0] raw);
        return (raw >= 6'(DECK_SIZE)) ? raw - 6'(DECK_SIZE) : raw;
    endfunction

endpackage

// File: rtl/card_decode.sv
// Combinational deck index (0..51) to card record; suits are blocks of 13.
module card_decode
    import blackjack_pkg::*;
(
    input  logic [5:0] index,
    output card_t      card
);

    logic [1:0] suit;
    logic [5:0] base;
    logic [5:0] rank6;

    always_comb begin
        suit = 2'd0;
        base = 6'd0;
        if (index >= 6'd39) begin
            suit = 2'd3;
            base = 6'd39;
        end else if (index >= 6'd26) begin
            suit = 2'd2;
            base = 6'd26;
        end else if (index >= 6'd13) begin
            suit = 2'd1;
            base = 6'd13;
        end
        rank6       = index - base + 6'd1;
        card.rank   = rank6[3:0];
        card.suit   = suit;
        card.point  = point_of(rank6[3:0]);
        card.is_ace = (rank6 == 6'd1);
    end

endmodule

// File: rtl/card_shoe.sv
// Deals cards without repeats: a free-running LFSR proposes an index and a
// used map walks forward past already-dealt cards.
module card_shoe
    import blackjack_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          RESHUFFLE_AT = 52
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       shuffle,
    output logic       card_valid,
    output logic [3:0] card_point,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic       card_is_ace,
    output logic       busy,
    output logic [5:0] cards_left
);

    localparam logic [5:0] RESHUF_LIMIT = 6'(RESHUFFLE_AT);

    shoe_state_t state, state_nxt;
    logic [15:0] lfsr, lfsr_nxt;
    logic [51:0] used;
    logic [5:0]  cand;
    logic [5:0]  dealt;
    logic        pend, pend_nxt;
    logic        load_cand, step, take, do_shuffle;
    card_t       dec_card, card_q;

    card_decode u_decode (
        .index (cand),
        .card  (dec_card)
    );

    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend;
        load_cand  = 1'b0;
        step       = 1'b0;
        take       = 1'b0;
        do_shuffle = 1'b0;
        case (state)
            ST_IDLE: begin
                if (shuffle) begin
                    state_nxt = ST_SHUFFLE;
                    pend_nxt  = req;
                end else if (req && (dealt >= RESHUF_LIMIT || cards_left == 6'd0)) begin
                    state_nxt = ST_SHUFFLE;
                    pend_nxt  = 1'b1;
                end else if (req) begin
                    load_cand = 1'b1;
                    state_nxt = ST_CHECK;
                end
            end
            ST_SHUFFLE: begin
                do_shuffle = 1'b1;
                if (pend) begin
                    pend_nxt  = 1'b0;
                    load_cand = 1'b1;
                    state_nxt = ST_CHECK;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (used[cand]) begin
                    step = 1'b1;
                end else begin
                    take      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            lfsr       <= LFSR_SEED;
            used       <= '0;
            cand       <= 6'd0;
            dealt      <= 6'd0;
            pend       <= 1'b0;
            cards_left <= 6'(DECK_SIZE);
            card_valid <= 1'b0;
            card_q     <= '0;
        end else begin
            state      <= state_nxt;
            lfsr       <= lfsr_nxt;
            pend       <= pend_nxt;
            card_valid <= take;
            if (load_cand)
                cand <= fold_index(lfsr[5:0]);
            else if (step)
                cand <= (cand == 6'd51) ? 6'd0 : cand + 6'd1;
            if (do_shuffle) begin
                used       <= '0;
                cards_left <= 6'(DECK_SIZE);
                dealt      <= 6'd0;
            end
            if (take) begin
                used[cand] <= 1'b1;
                cards_left <= cards_left - 6'd1;
                dealt      <= dealt + 6'd1;
                card_q     <= dec_card;
            end
        end
    end

    assign busy        = (state != ST_IDLE);
    assign card_point  = card_q.point;
    assign card_rank   = card_q.rank;
    assign card_suit   = card_q.suit;
    assign card_is_ace = card_q.is_ace;

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: the driver predicts each deal from a
// reference LFSR and deck map, the monitor checks every card_valid pulse.
module tb_card_shoe;
    import blackjack_pkg::*;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk, reset, req, shuffle;
    logic       card_valid, card_is_ace, busy;
    logic [3:0] card_point, card_rank;
    logic [1:0] card_suit;
    logic [5:0] cards_left;
    logic [5:0] dec_idx;
    card_t      dec_card;

    card_shoe #(.LFSR_SEED(SEED), .RESHUFFLE_AT(52)) dut (
        .clk(clk), .reset(reset), .req(req), .shuffle(shuffle),
        .card_valid(card_valid), .card_point(card_point), .card_rank(card_rank),
        .card_suit(card_suit), .card_is_ace(card_is_ace), .busy(busy),
        .cards_left(cards_left)
    );

    card_decode u_dec (.index(dec_idx), .card(dec_card));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         issued;
        int         cyc;
        int         limit;
        logic [3:0] point;
        logic [3:0] rank;
        logic [1:0] suit;
        logic       ace;
        logic [5:0] left;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   epoch = 0;
    int   seen_cnt = 0;

    logic [15:0] m_lfsr;
    bit          m_used[52];
    int          m_left, m_dealt;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) m_lfsr <= reset ? SEED : lfsr_step(m_lfsr);

    // Monitor: every card_valid pulse must match the oldest prediction.
    bit seen[52];
    int last_epoch = -1;
    always @(negedge clk) begin
        exp_t e;
        int   idx;
        if (card_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_card_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("deal_latency_bound", ((cyc - e.issued) <= e.limit) ? 1 : 0, 1);
                chk("card_rank", card_rank, e.rank);
                chk("card_suit", card_suit, e.suit);
                chk("card_point", card_point, e.point);
                chk("card_is_ace", card_is_ace, e.ace);
                chk("cards_left", cards_left, e.left);
                chk("busy_in_valid_cycle", busy, 0);
            end
            if (epoch != last_epoch) begin
                foreach (seen[i]) seen[i] = 1'b0;
                seen_cnt   = 0;
                last_epoch = epoch;
            end
            idx = int'(card_suit) * 13 + int'(card_rank) - 1;
            if (idx >= 0 && idx < 52) begin
                chk("no_repeat", seen[idx], 0);
                if (!seen[idx]) seen_cnt++;
                seen[idx] = 1'b1;
            end
        end
    end

    task automatic model_clear();
        foreach (m_used[i]) m_used[i] = 1'b0;
        m_left  = 52;
        m_dealt = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; req = 1'b0; shuffle = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_card_valid", card_valid, 0);
        chk("rst_card_point", card_point, 0);
        chk("rst_card_rank", card_rank, 0);
        chk("rst_card_suit", card_suit, 0);
        chk("rst_card_is_ace", card_is_ace, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cards_left", cards_left, 52);
        reset = 1'b0;
        model_clear();
        epoch++;
    endtask

    task automatic wait_done();
        int k = 0;
        while (q.size() != 0 && k < 80) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            chk("deal_timeout", 0, 1);
            q.delete();
        end
    endtask

    // Predict one deal from the current reference LFSR, then drive the request.
    task automatic deal(input bit with_shuffle, input bit check_busy);
        exp_t        e;
        logic [15:0] l;
        int          c, lat;
        bit          sh;
        @(negedge clk);
        l  = m_lfsr;
        sh = with_shuffle || m_dealt >= 52 || m_left == 0;
        lat = 2;
        if (sh) begin
            model_clear();
            l   = lfsr_step(l);
            lat = 3;
            epoch++;
        end
        c = int'(l[5:0]);
        if (c >= 52) c -= 52;
        while (m_used[c]) begin
            c = (c == 51) ? 0 : c + 1;
            lat++;
        end
        m_used[c] = 1'b1;
        m_left--;
        m_dealt++;
        e.issued = cyc;
        e.cyc    = cyc + lat;
        e.limit  = sh ? 54 : 53;
        e.suit   = 2'(c / 13);
        e.rank   = 4'(c % 13 + 1);
        e.point  = (c % 13 + 1 >= 10) ? 4'd10 : 4'(c % 13 + 1);
        e.ace    = (c % 13 == 0);
        e.left   = 6'(m_left);
        q.push_back(e);
        req = 1'b1; shuffle = with_shuffle;
        @(negedge clk);
        req = 1'b0; shuffle = 1'b0;
        if (check_busy) begin
            chk("busy_n_plus_1", busy, 1);
            @(negedge clk);
            chk("busy_n_plus_2", busy, 0);
        end
        wait_done();
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; shuffle = 1'b0; dec_idx = 6'd0;
        model_clear();
        reset_dut();

        // Single deal from fresh seed, then the rest of the deck.
        deal(1'b0, 1'b1);
        for (int i = 1; i < 52; i++) begin
            repeat (i % 4) @(negedge clk);
            deal(1'b0, 1'b0);
        end
        @(negedge clk);
        chk("full_deck_distinct", seen_cnt, 52);
        chk("full_deck_left", cards_left, 0);
        deal(1'b0, 1'b0);

        // Decoder corner indices.
        dec_idx = 6'd12; #1;
        chk("dec12_rank", dec_card.rank, 13);
        chk("dec12_point", dec_card.point, 10);
        chk("dec12_suit", dec_card.suit, 0);
        chk("dec12_ace", dec_card.is_ace, 0);
        dec_idx = 6'd10; #1;
        chk("dec10_rank", dec_card.rank, 11);
        chk("dec10_point", dec_card.point, 10);
        dec_idx = 6'd39; #1;
        chk("dec39_rank", dec_card.rank, 1);
        chk("dec39_suit", dec_card.suit, 3);
        chk("dec39_ace", dec_card.is_ace, 1);
        dec_idx = 6'd51; #1;
        chk("dec51_rank", dec_card.rank, 13);
        chk("dec51_suit", dec_card.suit, 3);

        // Shuffle and req together after 5 deals.
        reset_dut();
        for (int i = 0; i < 5; i++) deal(1'b0, 1'b0);
        deal(1'b1, 1'b0);

        // Reset while the last-card search is in CHECK.
        reset_dut();
        for (int i = 0; i < 51; i++) deal(1'b0, 1'b0);
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("mid_deal_busy", busy, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_reset_no_valid", card_valid, 0);
        chk("mid_reset_left", cards_left, 52);
        chk("mid_reset_busy", busy, 0);
        reset = 1'b0;
        model_clear();
        epoch++;
        repeat (3) @(negedge clk);
        deal(1'b0, 1'b0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
